// File: rtl/pi_series_engine_pkg.sv
// Shared types and constants for the Leibniz-series pi engine.
package pi_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        DIV,
        ACC,
        DONE
    } state_t;

    // Numerator constant M = 4 << frac_bits, clipped to the datapath width.
    function automatic logic [63:0] num_const(input int frac_bits, input int width);
        logic [63:0] m;
        m = 64'd4 << frac_bits;
        if (width < 64) begin
            m = m & ((64'd1 << width) - 64'd1);
        end
        return m;
    endfunction

endpackage

// File: rtl/pi_series_engine_if.sv
// Control/status bundle between a host (master) and the pi engine (slave).
interface pi_series_engine_if #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
);
    logic             start;
    logic [CNT_W-1:0] max_terms;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] pi_value;
    logic [CNT_W-1:0] terms_done;
    logic [WIDTH-1:0] divisor_out;

    modport master (
        output start, max_terms,
        input  busy, done, pi_value, terms_done, divisor_out
    );

    modport slave (
        input  start, max_terms,
        output busy, done, pi_value, terms_done, divisor_out
    );
endinterface

// File: rtl/pi_series_engine_divider.sv
// Iterative restoring divider: one quotient bit per cycle, MSB first.
module serial_divider #(
    parameter int WIDTH = 32
) (
    input  logic             clk_2,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] quotient,
    output logic             q_valid
);
    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             run_q, run_d;
    logic [WIDTH:0]   trial;

    always_comb begin
        // NOTE: every combinational output gets a default first, so no path leaves it unassigned and no latch is inferred.
        rem_d = rem_q;
        quo_d = quo_q;
        dsr_d = dsr_q;
        cnt_d = cnt_q;
        run_d = run_q;
        trial = {rem_q, quo_q[WIDTH-1]} - {1'b0, dsr_q};
        if (load) begin
            rem_d = '0;
            quo_d = dividend;
            dsr_d = divisor;
            cnt_d = '0;
            run_d = 1'b1;
        end else if (run_q) begin
            // A set top bit of the trial difference means a borrow: restore.
            if (!trial[WIDTH]) begin
                rem_d = trial[WIDTH-1:0];
            end else begin
                rem_d = {rem_q[WIDTH-2:0], quo_q[WIDTH-1]};
            end
            quo_d = {quo_q[WIDTH-2:0], ~trial[WIDTH]};
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == LAST) begin
                run_d = 1'b0;
            end
        end
    end

    // NOTE: only the control flops are reset; the datapath registers are always loaded before they are read.
    always_ff @(posedge clk_2) begin
        if (reset) begin
            cnt_q <= '0;
            run_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            run_q <= run_d;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_2) begin
        rem_q <= rem_d;
        quo_q <= quo_d;
        dsr_q <= dsr_d;
    end

    // q_valid marks the cycle whose closing edge shifts in the last quotient bit.
    assign q_valid  = run_q && (cnt_q == LAST);
    assign quotient = quo_q;

endmodule

// File: rtl/pi_series_engine.sv
// Sequential Leibniz-series pi accumulator sharing one serial divider.
module pi_series_engine
    import pi_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 24,
    parameter int CNT_W     = 16
) (
    input  logic               clk_2,
    input  logic               reset,
    pi_series_engine_if.slave  bus
);
    localparam logic [WIDTH-1:0] NUM     = WIDTH'(num_const(FRAC_BITS, WIDTH));
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic             sign_q, sign_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] max_q, max_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_inc;
    logic             div_load;
    logic             q_valid;
    logic [WIDTH-1:0] quotient;

    serial_divider #(.WIDTH(WIDTH)) u_div (
        .clk_2    (clk_2),
        .reset    (reset),
        .load     (div_load),
        .dividend (NUM),
        .divisor  (a_q),
        .quotient (quotient),
        .q_valid  (q_valid)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        a_d      = a_q;
        sign_d   = sign_q;
        cnt_d    = cnt_q;
        max_d    = max_q;
        done_d   = 1'b0;
        div_load = 1'b0;
        cnt_inc  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_W'(1);
        case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    acc_d   = '0;
                    cnt_d   = '0;
                    a_d     = WIDTH'(1);
                    sign_d  = 1'b0;
                    max_d   = bus.max_terms;
                    state_d = LOAD;
                end
            end
            LOAD: begin
                div_load = 1'b1;
                state_d  = DIV;
            end
            DIV: begin
                if (q_valid) begin
                    state_d = ACC;
                end
            end
            ACC: begin
                if (quotient == '0) begin
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    acc_d  = sign_q ? acc_q - quotient : acc_q + quotient;
                    cnt_d  = cnt_inc;
                    a_d    = a_q + WIDTH'(2);
                    sign_d = ~sign_q;
                    // Unlimited runs also stop once the term counter saturates.
                    if (((max_q != '0) && (cnt_inc == max_q)) ||
                        ((max_q == '0) && (cnt_inc == CNT_MAX))) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_2) begin
        if (reset) begin
            state_q <= IDLE;
            acc_q   <= '0;
            a_q     <= WIDTH'(1);
            sign_q  <= 1'b0;
            cnt_q   <= '0;
            max_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            a_q     <= a_d;
            sign_q  <= sign_d;
            cnt_q   <= cnt_d;
            max_q   <= max_d;
            done_q  <= done_d;
        end
    end

    assign bus.busy        = (state_q == LOAD) || (state_q == DIV) || (state_q == ACC);
    assign bus.done        = done_q;
    assign bus.pi_value    = acc_q;
    assign bus.terms_done  = cnt_q;
    assign bus.divisor_out = a_q;

endmodule

// File: tb/tb_pi_series_engine.sv
// Directed self-checking bench for pi_series_engine at 16/8 and 32/24 configurations.
module tb_pi_series_engine;
    import pi_pkg::*;

    localparam int LIMIT = 20000;

    logic clk_2 = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    always #5 clk_2 = ~clk_2;

    pi_series_engine_if #(.WIDTH(16), .CNT_W(16)) if16 ();
    pi_series_engine_if #(.WIDTH(32), .CNT_W(16)) if32 ();

    pi_series_engine #(.WIDTH(16), .FRAC_BITS(8), .CNT_W(16)) dut16 (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (if16)
    );

    pi_series_engine #(.WIDTH(32), .FRAC_BITS(24), .CNT_W(16)) dut32 (
        .clk_2 (clk_2),
        .reset (reset),
        .bus   (if32)
    );

    typedef struct {
        logic [15:0] max_terms;
        int          exp_pi;
        int          exp_terms;
        int          exp_div;
        int          exp_cycle;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Floor-based partial sum, stopping on a zero term or the term limit.
    function automatic int leibniz(input int m, input int limit, output int terms, output int a_end);
        int sum = 0;
        int a   = 1;
        int sgn = 1;
        terms = 0;
        while ((m / a) != 0 && (limit == 0 || terms < limit)) begin
            sum   = sum + sgn * (m / a);
            sgn   = -sgn;
            terms = terms + 1;
            a     = a + 2;
        end
        a_end = a;
        return sum;
    endfunction

    // Cycle 1 is the LOAD cycle following the edge that samples start.
    task automatic run16(input logic [15:0] mt, input bit hold_start, output int cyc,
                         output bit got, output bit busy_before,
                         output int s0, output int s1, output int s2);
        got = 0; busy_before = 0; s0 = -1; s1 = -1; s2 = -1;
        @(negedge clk_2);
        if16.start     = 1'b1;
        if16.max_terms = mt;
        @(posedge clk_2);
        cyc = 0;
        while (!got && cyc < LIMIT) begin
            @(negedge clk_2);
            if (!hold_start) if16.start = 1'b0;
            cyc++;
            if (cyc == 19) s0 = int'(if16.pi_value);
            if (cyc == 37) s1 = int'(if16.pi_value);
            if (cyc == 55) s2 = int'(if16.pi_value);
            if (if16.done) got = 1;
            else busy_before = if16.busy;
        end
    endtask

    initial begin
        int cyc, s0, s1, s2, model_pi, model_terms, model_a;
        bit got, bb;

        if16.start = 1'b0; if16.max_terms = '0;
        if32.start = 1'b0; if32.max_terms = '0;

        model_pi = leibniz(1024, 0, model_terms, model_a);
        vecs[0] = '{16'd1, 1024, 1, 3, 19};
        vecs[1] = '{16'd2, 683, 2, 5, 37};
        vecs[2] = '{16'd3, 887, 3, 7, 55};
        vecs[3] = '{16'd5, 854, 5, 11, 91};
        vecs[4] = '{16'd0, model_pi, 512, 1025, 513 * 18 + 1};

        repeat (3) @(posedge clk_2);
        @(negedge clk_2);
        reset = 1'b0;
        @(negedge clk_2);
        check("rst_pi16", if16.pi_value, 0);
        check("rst_terms16", if16.terms_done, 0);
        check("rst_div16", if16.divisor_out, 1);
        check("rst_busy16", if16.busy, 0);
        check("rst_done16", if16.done, 0);
        check("rst_state16", dut16.state_q, IDLE);
        check("rst_div32", if32.divisor_out, 1);
        check("rst_pi32", if32.pi_value, 0);

        for (int i = 0; i < 5; i++) begin
            run16(vecs[i].max_terms, 1'b0, cyc, got, bb, s0, s1, s2);
            check($sformatf("v%0d_done_seen", i), got, 1);
            check($sformatf("v%0d_done_cycle", i), cyc, vecs[i].exp_cycle);
            check($sformatf("v%0d_pi", i), if16.pi_value, vecs[i].exp_pi);
            check($sformatf("v%0d_terms", i), if16.terms_done, vecs[i].exp_terms);
            check($sformatf("v%0d_divisor", i), if16.divisor_out, vecs[i].exp_div);
            check($sformatf("v%0d_busy_before", i), bb, 1);
            check($sformatf("v%0d_busy_at_done", i), if16.busy, 0);
            if (i == 2) begin
                check("trace_acc1", s0, 1024);
                check("trace_acc2", s1, 683);
                check("trace_acc3", s2, 887);
            end
            @(negedge clk_2);
            check($sformatf("v%0d_done_low", i), if16.done, 0);
            check($sformatf("v%0d_pi_hold", i), if16.pi_value, vecs[i].exp_pi);
        end
        check("model_terms", model_terms, 512);
        check("model_a_end", model_a, 1025);

        // Reset during DIV of the second term.
        @(negedge clk_2);
        if16.start = 1'b1; if16.max_terms = 16'd3;
        @(negedge clk_2);
        if16.start = 1'b0;
        repeat (24) @(negedge clk_2);
        check("mid_state_div", dut16.state_q, DIV);
        check("mid_pi_before", if16.pi_value, 1024);
        reset = 1'b1;
        @(negedge clk_2);
        reset = 1'b0;
        check("abort_state", dut16.state_q, IDLE);
        check("abort_pi", if16.pi_value, 0);
        check("abort_terms", if16.terms_done, 0);
        check("abort_busy", if16.busy, 0);
        check("abort_div", if16.divisor_out, 1);
        run16(16'd1, 1'b0, cyc, got, bb, s0, s1, s2);
        check("rerun_cycle", cyc, 19);
        check("rerun_pi", if16.pi_value, 1024);
        check("rerun_terms", if16.terms_done, 1);

        // Start and reset together: reset wins.
        @(negedge clk_2);
        if16.start = 1'b1; reset = 1'b1;
        @(negedge clk_2);
        if16.start = 1'b0; reset = 1'b0;
        check("sr_state", dut16.state_q, IDLE);
        check("sr_busy", if16.busy, 0);
        check("sr_pi", if16.pi_value, 0);

        // Start held high for a whole run.
        run16(16'd3, 1'b1, cyc, got, bb, s0, s1, s2);
        check("held_cycle", cyc, 55);
        check("held_pi", if16.pi_value, 887);
        @(negedge clk_2);
        check("held_restart_pi", if16.pi_value, 0);
        check("held_restart_terms", if16.terms_done, 0);
        check("held_restart_busy", if16.busy, 1);
        check("held_restart_done", if16.done, 0);
        check("held_restart_state", dut16.state_q, LOAD);
        if16.start = 1'b0;
        reset = 1'b1;
        @(negedge clk_2);
        reset = 1'b0;

        // 32-bit configuration, four terms.
        @(negedge clk_2);
        if32.start = 1'b1; if32.max_terms = 16'd4;
        @(posedge clk_2);
        cyc = 0; got = 0;
        while (!got && cyc < LIMIT) begin
            @(negedge clk_2);
            if32.start = 1'b0;
            cyc++;
            if (if32.done) got = 1;
        end
        check("w32_done_seen", got, 1);
        check("w32_cycle", cyc, 4 * 34 + 1);
        check("w32_pi", if32.pi_value, 48574035);
        check("w32_terms", if32.terms_done, 4);
        check("w32_divisor", if32.divisor_out, 9);
        check("w32_busy", if32.busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pi_series_engine.md
Name: pi_series_engine

Overview:
- Sequential, parametrised successor to the FPGA-demo pi accumulator.
- Computes a fixed-point partial sum of the Leibniz series: pi = sum over k of (-1)^k * 4/(2k+1).
- Uses one shared iterative restoring divider instead of combinational dividers.
- Adds a start/busy/done handshake, a term limit, early termination on a zero term, and a live partial sum for LCD/LED display in the top level.

Parameters:
- WIDTH, 32: datapath width of numerator, divisor, quotient and accumulator. Must be >= FRAC_BITS+4.
- FRAC_BITS, 24: fractional bits of the result. The numerator constant is M = 4 << FRAC_BITS.
- CNT_W, 16: width of the term limit and term counter.

Ports:
- clk_2  in  1  system clock
- reset  in  1  synchronous, active-high reset
- start  in  1  request a new computation; sampled only in IDLE or DONE
- max_terms  in  CNT_W  term limit, latched at start; 0 = unlimited (stop only on zero term)
- busy  out  1  high from the cycle after start is accepted until DONE is entered
- done  out  1  one-cycle pulse on entry to DONE
- pi_value  out  WIDTH  running partial sum, unsigned, FRAC_BITS fractional bits
- terms_done  out  CNT_W  number of nonzero terms accumulated
- divisor_out  out  WIDTH  current odd divisor a (debug/LCD)

Behaviour:
- Reset (synchronous, clk_2 edge with reset=1):
  - state=IDLE, busy=0, done=0, pi_value=0, terms_done=0, divisor_out=1, sign=+.
  - Reset mid-computation aborts immediately to these values.
- FSM states: IDLE, LOAD, DIV, ACC, DONE.
- IDLE/DONE + start=1:
  - Clear pi_value and terms_done; a=1; sign=+; latch max_terms.
  - Next state LOAD.
  - start while busy is ignored.
- LOAD, 1 cycle: load the divider with M and a. Next state DIV.
- DIV, exactly WIDTH cycles:
  - Restoring division, one quotient bit per cycle, MSB first.
  - Quotient q = floor(M/a) is valid on the last DIV cycle. Next state ACC.
- ACC, 1 cycle:
  - If q == 0: no update; next state DONE.
  - Else:
    - pi_value += q if sign=+, else -= q.
    - terms_done += 1; a += 2; sign toggles.
  - If max_terms != 0 and the new terms_done == max_terms: next state DONE. Else next state LOAD.
- Timing:
  - Each term costs WIDTH+2 cycles.
  - The first LOAD is the cycle after start is sampled.
  - done pulses in the first DONE cycle, the same cycle busy falls.
- DONE: outputs hold until the next start or reset. done is low after its first cycle.
- Arithmetic and width rules:
  - The sequence starts with +, so the partial sum stays in [0, M]; no sign bit is needed.
  - a is odd and >= 1, so division by zero cannot occur.
  - WIDTH >= FRAC_BITS+4 guarantees q reaches 0 (a > M) before a can wrap.
  - terms_done saturates at 2^CNT_W-1. When saturation is reached with max_terms=0, the engine goes to DONE.
- Simultaneous start and reset: reset wins.
- pi_value updates only in ACC, so the top level can display it live.

Decomposition:
- Package pi_pkg:
  - typedef enum state_t {IDLE, LOAD, DIV, ACC, DONE}.
  - function num_const(FRAC_BITS, WIDTH) returning M.
- Sub-module serial_divider:
  - Parametrised by WIDTH.
  - Ports: clk_2, reset, load, dividend, divisor, quotient, q_valid (pulse after WIDTH iterations).
  - Remainder is kept internal.
- The engine holds the FSM, accumulator, divisor/sign registers and counter.

Test Plan:
- WIDTH=16, FRAC_BITS=8 (M=1024), max_terms=1, start pulse -> pi_value=1024, terms_done=1; done pulses exactly 19 cycles after the start-sampling edge (1+18).
- Same config, max_terms=3 -> pi_value sequence 1024, 683, 887 at each ACC; final 887, terms_done=3, divisor_out=7; done after 3*18+1 = 55 cycles.
- Same config, max_terms=0 -> stops on the first zero quotient (a=1025) with terms_done=512; pi_value matches a software model of the floor-based sum; busy falls the same cycle done rises.
- Reset asserted during DIV of the 2nd term -> next cycle state=IDLE, pi_value=0, terms_done=0, busy=0, divisor_out=1; a following start runs normally from a=1.
- start held high throughout a max_terms=3 run -> start is ignored while busy; done pulses once; a new run starts the cycle after DONE is entered, and pi_value clears to 0.
- WIDTH=32, FRAC_BITS=24, max_terms=4 -> pi_value equals sum(+/-floor(2^26/a)) for a=1,3,5,7, i.e. 67108864-22369621+13421772-9586980 = 48574035.
